// File: rtl/gf16_ssm_sbox_outstage_if.sv
// rtl/gf16_ssm_sbox_outstage_if.sv - shared byte/inverse/result signals of the masked S-box output stage
interface gf16_ssm_sbox_outstage_if;
  logic       byte_valid;
  logic [7:0] a0b0c0d0e0f0g0h0;
  logic [7:0] a1b1c1d1e1f1g1h1;
  logic       inv_valid;
  logic [3:0] x0y0z0t0;
  logic [3:0] x1y1z1t1;
  logic [7:0] ran;
  logic       out_valid;
  logic [7:0] out0;
  logic [7:0] out1;
  logic       err;

  modport master (
    output byte_valid, a0b0c0d0e0f0g0h0, a1b1c1d1e1f1g1h1,
    output inv_valid, x0y0z0t0, x1y1z1t1, ran,
    input  out_valid, out0, out1, err
  );

  modport slave (
    input  byte_valid, a0b0c0d0e0f0g0h0, a1b1c1d1e1f1g1h1,
    input  inv_valid, x0y0z0t0, x1y1z1t1, ran,
    output out_valid, out0, out1, err
  );
endinterface

// File: rtl/gf16_ssm_sbox_outstage.sv
// rtl/gf16_ssm_sbox_outstage.sv - two-share masked GF(2^4) output multiply stage of the tower-field S-box (option: OUT_REG_EN)
module gf16_ssm_sbox_outstage (
  input  logic                           clk,
  input  logic                           rst,
  gf16_ssm_sbox_outstage_if.slave        bus
);

  // GF(2^4) product, modulus x^4+x+1: carry-less multiply then fold x^4..x^6
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ ({3'b000, a} << i);
    end
    return {p[3] ^ p[6],
            p[2] ^ p[5] ^ p[6],
            p[1] ^ p[4] ^ p[5],
            p[0] ^ p[4]};
  endfunction

  logic       held;
  logic [7:0] hold0, hold1;
  logic       err_q;
  logic       v_q;
  logic [3:0] inner_hi0, inner_hi1, cross_hi0, cross_hi1;
  logic [3:0] inner_lo0, inner_lo1, cross_lo0, cross_lo1;

  // Share-wise multiplier operands from the held byte: b = hi, and b = hi ^ lo
  logic [3:0] b_hi0, b_hi1, b_lo0, b_lo1;
  logic [3:0] r_hi, r_lo;
  assign b_hi0 = hold0[7:4];
  assign b_hi1 = hold1[7:4];
  assign b_lo0 = hold0[7:4] ^ hold0[3:0];
  assign b_lo1 = hold1[7:4] ^ hold1[3:0];
  assign r_hi  = bus.ran[3:0];
  assign r_lo  = bus.ran[7:4];

  // Byte delay line and alignment tracking; a byte is held for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held  <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
      err_q <= 1'b0;
    end else begin
      held <= bus.byte_valid;
      if (bus.byte_valid) begin
        hold0 <= bus.a0b0c0d0e0f0g0h0;
        hold1 <= bus.a1b1c1d1e1f1g1h1;
      end
      if (bus.inv_valid && !held) err_q <= 1'b1;
    end
  end

  // Register-separated partial products; cross-domain terms are refreshed with r before the flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= 1'b0;
      inner_hi0 <= '0;
      inner_hi1 <= '0;
      cross_hi0 <= '0;
      cross_hi1 <= '0;
      inner_lo0 <= '0;
      inner_lo1 <= '0;
      cross_lo0 <= '0;
      cross_lo1 <= '0;
    end else begin
      v_q <= bus.inv_valid;
      if (bus.inv_valid) begin
        inner_hi0 <= gf16_mul(bus.x0y0z0t0, b_hi0);
        inner_hi1 <= gf16_mul(bus.x1y1z1t1, b_hi1);
        cross_hi0 <= gf16_mul(bus.x0y0z0t0, b_hi1) ^ r_hi;
        cross_hi1 <= gf16_mul(bus.x1y1z1t1, b_hi0) ^ r_hi;
        inner_lo0 <= gf16_mul(bus.x0y0z0t0, b_lo0);
        inner_lo1 <= gf16_mul(bus.x1y1z1t1, b_lo1);
        cross_lo0 <= gf16_mul(bus.x0y0z0t0, b_lo1) ^ r_lo;
        cross_lo1 <= gf16_mul(bus.x1y1z1t1, b_lo0) ^ r_lo;
      end
    end
  end

  // Compression after the register stage, each share stays in its own domain
  logic [7:0] share0, share1;
  assign share0 = {inner_hi0 ^ cross_hi0, inner_lo0 ^ cross_lo0};
  assign share1 = {inner_hi1 ^ cross_hi1, inner_lo1 ^ cross_lo1};

`ifdef OUT_REG_EN
  logic       ov_q;
  logic [7:0] o0_q, o1_q;

  // Optional output flops so the shares leave the stage glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
      o0_q <= '0;
      o1_q <= '0;
    end else begin
      ov_q <= v_q;
      o0_q <= share0;
      o1_q <= share1;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out0      = o0_q;
  assign bus.out1      = o1_q;
`else
  assign bus.out_valid = v_q;
  assign bus.out0      = share0;
  assign bus.out1      = share1;
`endif

  assign bus.err = err_q;

endmodule

// File: tb/tb_gf16_ssm_sbox_outstage.sv
// tb/tb_gf16_ssm_sbox_outstage.sv - randomized self-checking bench for gf16_ssm_sbox_outstage
module tb_gf16_ssm_sbox_outstage;

`ifdef OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  gf16_ssm_sbox_outstage_if bus ();

  gf16_ssm_sbox_outstage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: shift-and-add multiply in GF(2^4), x^4 = x + 1
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] ginv(input logic [3:0] x);
    for (int j = 1; j < 16; j++) begin
      if (gmul(x, 4'(j)) == 4'h1) return 4'(j);
    end
    return 4'h0;
  endfunction

  // Tower-field inverse of the unshared byte given the upstream inverse d
  function automatic logic [7:0] model(input logic [7:0] a, input logic [3:0] d);
    return {gmul(d, a[7:4]), gmul(d, a[7:4] ^ a[3:0])};
  endfunction

  function automatic logic [3:0] norm_inv(input logic [7:0] a);
    return ginv(gmul(4'h8, gmul(a[7:4], a[7:4])) ^ gmul(a[7:4], a[3:0]) ^ gmul(a[3:0], a[3:0]));
  endfunction

  typedef struct {
    bit         chk;
    bit         exact;
    logic [7:0] v;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   nvalid = 0;
  bit   prev_ok = 0;
  logic [7:0] prev_byte = '0;

  // Scoreboard: every out_valid pulse must match the oldest pending expectation at its due cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid) begin
      nvalid++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("latency", 32'(cyc), 32'(e.due));
        if (e.chk) check("data", 32'(bus.out0 ^ bus.out1), 32'(e.v));
        if (e.exact) begin
          check("share0", 32'(bus.out0), 32'(e.v));
          check("share1", 32'(bus.out1), 32'(0));
        end
      end
    end
  end

  task automatic drive(input logic bv, input logic [7:0] b0, input logic [7:0] b1,
                       input logic iv, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [7:0] r, input bit exact);
    exp_t e;
    bus.byte_valid       = bv;
    bus.a0b0c0d0e0f0g0h0 = b0;
    bus.a1b1c1d1e1f1g1h1 = b1;
    bus.inv_valid        = iv;
    bus.x0y0z0t0         = d0;
    bus.x1y1z1t1         = d1;
    bus.ran              = r;
    if (iv) begin
      e.chk   = prev_ok;
      e.exact = exact;
      e.v     = model(prev_byte, d0 ^ d1);
      e.due   = cyc + LAT;
      exp_q.push_back(e);
    end
    prev_ok = bv;
    if (bv) prev_byte = b0 ^ b1;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.inv_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
  endtask

  // Random byte shares with a matching random split of the true GF(2^4) inverse
  task automatic rand_item(input logic bv, input logic iv, input logic [7:0] nb,
                           input logic [7:0] pb);
    logic [7:0] m;
    logic [3:0] d, dm;
    m  = 8'($urandom);
    d  = norm_inv(pb);
    dm = 4'($urandom);
    drive(bv, nb ^ m, m, iv, d ^ dm, dm, 8'($urandom), 1'b0);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] bytes [16];
    int         base;
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.a0b0c0d0e0f0g0h0 = '0;
    bus.a1b1c1d1e1f1g1h1 = '0;
    bus.inv_valid = 1'b0;
    bus.x0y0z0t0 = '0;
    bus.x1y1z1t1 = '0;
    bus.ran = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out0", 32'(bus.out0), 32'(0));
    check("rst_out1", 32'(bus.out1), 32'(0));
    check("rst_err", 32'(bus.err), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    drive(1'b1, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'h0, 4'h0, 8'hA5, 1'b0);
    drive(1'b1, 8'h10, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'hF, 4'h0, 8'h00, 1'b1);
    drive(1'b1, 8'h4A, 8'h5A, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'hC, 4'h3, 8'h3C, 1'b0);
    drive(1'b1, 8'h76, 8'h77, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'h9, 4'h8, 8'h5E, 1'b0);
    idle(4);
    check("directed_drain", 32'(exp_q.size()), 32'(0));
    check("err_clean", 32'(bus.err), 32'(0));

    // 16 back-to-back random bytes, inverse paired one cycle later
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
    base = nvalid;
    rand_item(1'b1, 1'b0, bytes[0], 8'h00);
    for (int i = 1; i < 16; i++) rand_item(1'b1, 1'b1, bytes[i], bytes[i-1]);
    rand_item(1'b0, 1'b1, 8'h00, bytes[15]);
    idle(LAT + 2);
    check("stream_pulses", 32'(nvalid - base), 32'(16));
    check("stream_drain", 32'(exp_q.size()), 32'(0));

    // Reset mid-stream: outputs clear at once, nothing stale afterwards
    rand_item(1'b1, 1'b0, 8'h3B, 8'h00);
    rand_item(1'b1, 1'b1, 8'hC4, 8'h3B);
    rand_item(1'b1, 1'b1, 8'h91, 8'hC4);
    rst = 1'b1;
    exp_q.delete();
    prev_ok = 0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_out0", 32'(bus.out0), 32'(0));
    check("midrst_out1", 32'(bus.out1), 32'(0));
    base = nvalid;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    check("no_stale_valid", 32'(nvalid - base), 32'(0));

    // Misalignment: inverse with nothing held sets a sticky error
    drive(1'b0, 8'h00, 8'h00, 1'b1, 4'h5, 4'h2, 8'h00, 1'b0);
    check("err_set", 32'(bus.err), 32'(1));
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      rand_item(1'b1, 1'b0, b, 8'h00);
      rand_item(1'b0, 1'b1, 8'h00, b);
      check("err_sticky", 32'(bus.err), 32'(1));
    end
    idle(LAT + 2);
    check("misalign_drain", 32'(exp_q.size()), 32'(0));
    rst = 1'b1;
    #1;
    check("err_cleared", 32'(bus.err), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
